// File: rtl/xpar_btn_resp.sv
// Push-button responder on the picoVersat parallel bus: synchronizes and debounces
// buttons, queues press/release events in a FIFO, and exposes them through four registers.
module xpar_btn_resp #(
    parameter int PAR_ADDR_W = 4,
    parameter int DATA_W     = 32,
    parameter int N_BTN      = 6,
    parameter int DB_W       = 20,
    parameter int DB_DEFAULT = 1000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAR_ADDR_W-1:0] par_addr,
    input  logic                  par_re,
    input  logic                  par_we,
    input  logic [DATA_W-1:0]     par_wdata,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [N_BTN-1:0]      btn_in,
    output logic                  evt_pending
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DB_W-1:0] DB_MIN = DB_W'(N_BTN + 1);

    // A limit of at least N_BTN+1 lets the arbiter drain every pending flag before it can re-arm.
    function automatic logic [DB_W-1:0] sat_db_lim(input logic [DB_W-1:0] v);
        return (v < DB_MIN) ? DB_MIN : v;
    endfunction

    logic [N_BTN-1:0] sync_p0, sync_p1;
    logic [N_BTN-1:0] stable, pend, kind, flip, grant;
    logic [DB_W-1:0]  cnt [N_BTN];
    logic [DB_W-1:0]  db_lim, lim_m1;
    logic [4:0]       fifo_mem [FIFO_DEPTH];
    logic [4:0]       head, arb_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             overflow, arb_vld, pop, flush, full, push_ok;
    logic [1:0]       reg_sel;
    logic             unused_bits;

    assign reg_sel     = par_addr[1:0];
    assign unused_bits = ^{par_addr[PAR_ADDR_W-1:2], par_wdata[DATA_W-1:DB_W]};
    assign lim_m1      = db_lim - DB_W'(1);
    assign head        = fifo_mem[rd_ptr];
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign pop         = par_re && !par_we && (reg_sel == 2'd1) && (count != '0);
    assign flush       = par_we && (reg_sel == 2'd2) && par_wdata[0];
    assign push_ok     = arb_vld && !flush && (!full || pop);

    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++)
            flip[i] = (sync_p1[i] != stable[i]) && (cnt[i] == lim_m1);
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        arb_vld   = 1'b0;
        arb_entry = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend[i] && !found) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                arb_vld   = 1'b1;
                arb_entry = {kind[i], 4'(i)};
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push_ok && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push_ok)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            stable      <= '0;
            pend        <= '0;
            kind        <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
            db_lim      <= DB_W'(DB_DEFAULT);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            evt_pending <= 1'b0;
        end else begin
            // stage p0/p1: two-flop synchronizer
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            // debounce: count consecutive cycles the synchronized level differs from stable
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_p1[i] == stable[i] || flip[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + DB_W'(1);
            end
            stable <= stable ^ flip;
            kind   <= (kind & ~flip) | (sync_p1 & flip);
            pend   <= (pend & ~grant) | flip;
            // event FIFO bookkeeping
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (arb_vld && full && !pop) overflow <= 1'b1;
            end
            count       <= count_nxt;
            evt_pending <= (count_nxt != '0);
            if (par_we && reg_sel == 2'd3)
                db_lim <= sat_db_lim(par_wdata[DB_W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= arb_entry;
    end

    always_comb begin
        rd_data = '0;
        if (par_re) begin
            case (reg_sel)
                2'd0: rd_data[N_BTN-1:0] = stable;
                2'd1: if (count != '0) begin
                    rd_data[DATA_W-1] = 1'b1;
                    rd_data[8]        = head[4];
                    rd_data[3:0]      = head[3:0];
                end
                2'd2: begin
                    rd_data[8]       = overflow;
                    rd_data[CNT_W-1:0] = count;
                end
                default: rd_data[DB_W-1:0] = db_lim;
            endcase
        end
    end
endmodule

// File: doc/xpar_btn_resp.md
Name: xpar_btn_resp

Overview:
- Responder (slave) on the picoVersat external parallel interface; the CPU's par_addr/par_re/par_we/par_out drive it, and its rd_data returns on par_in.
- Synchronizes and debounces arcade push-buttons.
- Converts debounced press/release transitions into events queued in a small FIFO that game firmware polls.
- Also exposes live button state and a programmable debounce time.

Parameters:
- PAR_ADDR_W, 4: width of par_addr; only bits [1:0] decoded, upper bits ignored.
- DATA_W, 32: parallel data width.
- N_BTN, 6: number of button inputs (≤16).
- DB_W, 20: debounce counter width.
- DB_DEFAULT, 1000000: reset debounce limit, 10 ms at 100 MHz.
- FIFO_DEPTH, 8: event FIFO entries, power of 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- par_addr  in  PAR_ADDR_W  register address from CPU.
- par_re  in  1  read strobe, one cycle per access.
- par_we  in  1  write strobe, one cycle per access.
- par_wdata  in  DATA_W  write data (CPU par_out).
- rd_data  out  DATA_W  read data to CPU par_in; combinational from par_addr.
- btn_in  in  N_BTN  raw asynchronous buttons, active-high.
- evt_pending  out  1  registered; 1 while FIFO non-empty.

Behaviour:
- Reset: all sync/debounce state, stable state, pending flags, FIFO pointers/count, overflow, evt_pending <= 0; db_lim <= DB_DEFAULT. rst sampled only on rising clk, low = reset; reset mid-access discards the access (no pop, no write).
- Per button: 2-FF synchronizer → sync[i].
  - Counter cnt[i] cleared when sync[i]==stable[i], else incremented.
  - When cnt[i]==db_lim-1 and still differing: stable[i]<=sync[i], cnt[i]<=0, pend[i]<=1, kind[i]<=sync[i] (1 press, 0 release).
  - A glitch shorter than db_lim cycles produces no change.
- Arbiter: each cycle, lowest-index set pend[i] enqueues entry {kind, i[3:0]} and clears pend[i]. Max one enqueue per cycle. Simultaneous stable changes drain over successive cycles.
- db_lim writes are saturated to min N_BTN+1, so a button can never re-pend before its previous event is enqueued.
- FIFO (5-bit entries):
  - Push when full: entry dropped, overflow<=1 (sticky).
  - Pop and push in same cycle: both happen, count unchanged, even when full (no overflow).
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_pending = (count!=0), updated at the same edge as count.
- Register map, addr[1:0]:
  - 0 R: {0, stable[N_BTN-1:0]}. W: ignored.
  - 1 R: {valid bit31, 0, kind bit8, 0, code[3:0]}; valid = FIFO non-empty, fields = head entry (all zero if empty). A read with par_re pops at that clock edge. W: ignored.
  - 2 R: {0, overflow bit8, 0, count[log2(FIFO_DEPTH):0]}. W: if par_wdata[0]=1, flush FIFO (ptrs, count=0) and clear overflow; a push in the same cycle is discarded.
  - 3 R: {0, db_lim[DB_W-1:0]}. W: db_lim <= saturated par_wdata[DB_W-1:0]; takes effect next cycle; running counters not cleared.
- rd_data is 0 when par_re=0.
- par_re and par_we both high: write executes, read side effect (pop) suppressed.

Test Plan:
- Reset, db_lim=16 via addr 3; raise btn_in[2] and hold 40 cycles → addr 0 reads 0x4 after 2+16 cycles. addr 1 read returns 0x80000102. evt_pending 1→0 on the edge after the pop.
- btn_in[0] glitch high 10 cycles (db_lim=16) → no event, addr 2 count=0, addr 0 = 0.
- Buttons 1,3,4 change in same debounce cycle → three entries in order codes 1,3,4, count=3 after 3 cycles.
- Generate 9 presses/releases with no pops (DEPTH 8) → count=8, addr 2 bit8=1. First 8 events read back in order. Write 1 to addr 2 → reads 0x0.
- FIFO full, pop read coincides with arbiter push → count stays 8, overflow stays 0, pushed entry appears last.
- Write 2 to addr 3 → readback N_BTN+1 (7). Assert rst=0 mid-debounce for 1 cycle → all state cleared, db_lim reads DB_DEFAULT.
